// File: rtl/chan_select_arbiter_pkg.sv
// Shared types for the channel select arbiter: selection policy and output-stage state.
package chan_sel_pkg;

    typedef enum logic [1:0] {SEL_FIXED, SEL_RR, SEL_UNIQUE, SEL_RSVD} sel_mode_e;
    typedef enum logic {FSM_IDLE, FSM_HOLD} sel_state_e;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_select_arbiter_if.sv
// Producer-side request bundle and consumer-side output handshake of the arbiter.
interface chan_select_arbiter_if
    import chan_sel_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    localparam int CH_W = ch_width(N_CH);

    logic [1:0]             mode;
    logic [N_CH-1:0]        req_valid;
    logic [N_CH*DATA_W-1:0] req_data;
    logic [N_CH-1:0]        req_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W-1:0]        out_ch;
    logic                   out_ready;
    logic                   violation;
    logic [CNT_W-1:0]       viol_cnt;

    modport master (
        output mode, req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_ch, violation, viol_cnt
    );

    modport slave (
        input  mode, req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_ch, violation, viol_cnt
    );

endinterface

// File: rtl/chan_select_arbiter_find_first.sv
// Find-first-set over N_CH request bits, scanning upward from base and wrapping.
module chan_find_first #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] base,
    output logic            found,
    output logic [CH_W-1:0] idx
);

    int j;

    // Scan from the farthest offset down so the nearest hit to base wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            j = int'(base) + k;
            if (j >= N_CH) begin
                j = j - N_CH;
            end
            if (req[j]) begin
                found = 1'b1;
                idx   = CH_W'(j);
            end
        end
    end

endmodule

// File: rtl/chan_select_arbiter.sv
// N-channel valid/ready request selector with fixed, round-robin and unique-checked
// policies feeding a single registered output stage.
module chan_select_arbiter
    import chan_sel_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chan_select_arbiter_if.slave bus
);

    localparam int CH_W = ch_width(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);

    sel_state_e          state_reg, state_next;
    logic [CH_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [DATA_W-1:0]   out_data_reg, out_data_next;
    logic [CH_W-1:0]     out_ch_reg, out_ch_next;
    logic                violation_reg, violation_next;
    logic [CNT_W-1:0]    viol_cnt_reg, viol_cnt_next;

    logic [DATA_W-1:0]   data_arr [N_CH];
    sel_mode_e           mode_sel;
    logic [CH_W-1:0]     base;
    logic [CH_W-1:0]     win;
    logic                found;
    logic                multi_req;
    logic                capture;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign mode_sel  = sel_mode_e'(bus.mode);
    assign base      = (mode_sel == SEL_RR) ? rr_ptr_reg : '0;
    assign multi_req = |(bus.req_valid & (bus.req_valid - N_CH'(1)));

    chan_find_first #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_find_first (
        .req   (bus.req_valid),
        .base  (base),
        .found (found),
        .idx   (win)
    );

    // Gating with rst_n keeps any handshake from completing while reset is held.
    assign capture = rst_n && found && ((state_reg == FSM_IDLE) || bus.out_ready);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_grant
            assign bus.req_ready[gi] = capture && (win == CH_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        out_data_next  = out_data_reg;
        out_ch_next    = out_ch_reg;
        violation_next = 1'b0;
        viol_cnt_next  = viol_cnt_reg;

        if (capture) begin
            state_next    = FSM_HOLD;
            out_data_next = data_arr[win];
            out_ch_next   = win;
            if (mode_sel == SEL_RR) begin
                rr_ptr_next = (win == LAST_CH) ? '0 : win + CH_W'(1);
            end
            if ((mode_sel == SEL_UNIQUE) && multi_req) begin
                violation_next = 1'b1;
                if (viol_cnt_reg != CNT_MAX) begin
                    viol_cnt_next = viol_cnt_reg + CNT_W'(1);
                end
            end
        end else if ((state_reg == FSM_HOLD) && bus.out_ready) begin
            state_next = FSM_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= FSM_IDLE;
            rr_ptr_reg    <= '0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            violation_reg <= 1'b0;
            viol_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            out_data_reg  <= out_data_next;
            out_ch_reg    <= out_ch_next;
            violation_reg <= violation_next;
            viol_cnt_reg  <= viol_cnt_next;
        end
    end

    assign bus.out_valid = (state_reg == FSM_HOLD);
    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.violation = violation_reg;
    assign bus.viol_cnt  = viol_cnt_reg;

endmodule
